// File: rtl/rv32i_types.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and small helpers for beat addressing and word selection.
package rv32i_types;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } mem_arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } mem_owner_t;

    // Aligns a byte address down to its 64-bit beat.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

    // Picks the 32-bit word of a beat addressed by bit 2 of the address.
    function automatic logic [31:0] word_select(input logic [63:0] beat, input logic half);
        return half ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the backing-memory port.
// The arbiter uses the slave view; the core and memory use the master view.
interface mem_port_arbiter_if;

    logic        flush;

    logic [31:0] imem_addr;
    logic        input_valid;
    logic [31:0] imem_rdata;
    logic [31:0] imem_raddr;
    logic        imem_resp;
    logic        imem_stall;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    modport slave (
        input  flush,
        input  imem_addr, input_valid,
        output imem_rdata, imem_raddr, imem_resp, imem_stall,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output flush,
        output imem_addr, input_valid,
        input  imem_rdata, imem_raddr, imem_resp, imem_stall,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/beat_merge.sv
// Byte-masked merge of a 32-bit store word into one half of a 64-bit beat.
// Purely combinational so it can be shared with the cache write path.
module beat_merge (
    input  logic [63:0] beat,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        half,
    output logic [63:0] merged
);

    // Replace each enabled byte lane inside the half selected by address bit 2.
    always_comb begin
        merged = beat;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                if (half) begin
                    merged[32 + 8*i +: 8] = wdata[8*i +: 8];
                end else begin
                    merged[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one 64-bit backing-memory
// port, one transaction at a time, with read-modify-write for sub-beat stores
// and suppression of fetch responses squashed by a pipeline flush.
module mem_port_arbiter #(
    parameter bit FAIR_ALTERNATE = 1'b1
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    import rv32i_types::*;

    mem_arb_state_t state;
    mem_owner_t     owner;
    logic [31:0]    lat_addr;
    logic [3:0]     lat_wmask;
    logic [31:0]    lat_wdata;
    logic [63:0]    beat;
    logic           squash;
    logic           last_was_data;

    logic [63:0]    merged;
    logic           data_req;
    logic           fetch_sel;
    logic           data_sel;
    logic           resp_pending;
    logic           is_store;

    // While a response pulse is still visible the requester has not yet had a
    // chance to drop or change its request, so IDLE must not sample it.
    assign resp_pending = bus.imem_resp | bus.dmem_resp;
    assign data_req     = (bus.dmem_rmask != 4'b0000) | (bus.dmem_wmask != 4'b0000);
    assign fetch_sel    = ~resp_pending & bus.input_valid & ~bus.flush &
                          (~data_req | (FAIR_ALTERNATE & last_was_data));
    assign data_sel     = ~resp_pending & data_req & ~fetch_sel;
    assign is_store     = (owner == OWN_D) & (lat_wmask != 4'b0000);
    assign bus.imem_stall = rst & bus.input_valid & ~((state == IDLE) & fetch_sel);

    beat_merge u_beat_merge (
        .beat   (bus.bmem_rdata),
        .wdata  (lat_wdata),
        .wmask  (lat_wmask),
        .half   (lat_addr[2]),
        .merged (merged)
    );

    // Transaction FSM with registered bmem requests and requester responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= OWN_I;
            lat_addr       <= '0;
            lat_wmask      <= '0;
            lat_wdata      <= '0;
            beat           <= '0;
            squash         <= 1'b0;
            last_was_data  <= 1'b0;
            bus.imem_rdata <= '0;
            bus.imem_raddr <= '0;
            bus.imem_resp  <= 1'b0;
            bus.dmem_rdata <= '0;
            bus.dmem_resp  <= 1'b0;
            bus.bmem_addr  <= '0;
            bus.bmem_read  <= 1'b0;
            bus.bmem_write <= 1'b0;
            bus.bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.imem_resp <= 1'b0;
                    bus.dmem_resp <= 1'b0;
                    if (fetch_sel) begin
                        owner         <= OWN_I;
                        lat_addr      <= bus.imem_addr;
                        lat_wmask     <= 4'b0000;
                        bus.bmem_addr <= beat_addr(bus.imem_addr);
                        bus.bmem_read <= 1'b1;
                        state         <= RD_ISSUE;
                    end else if (data_sel) begin
                        owner         <= OWN_D;
                        lat_addr      <= bus.dmem_addr;
                        lat_wmask     <= bus.dmem_wmask;
                        lat_wdata     <= bus.dmem_wdata;
                        bus.bmem_addr <= beat_addr(bus.dmem_addr);
                        bus.bmem_read <= 1'b1;
                        state         <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (bus.flush && owner == OWN_I) begin
                        squash <= 1'b1;
                    end
                    if (bus.bmem_ready) begin
                        bus.bmem_read <= 1'b0;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.flush && owner == OWN_I) begin
                        squash <= 1'b1;
                    end
                    if (bus.bmem_rvalid && bus.bmem_raddr == bus.bmem_addr) begin
                        if (is_store) begin
                            beat           <= merged;
                            bus.bmem_wdata <= merged;
                            bus.bmem_write <= 1'b1;
                            state          <= WR_ISSUE;
                        end else begin
                            beat  <= bus.bmem_rdata;
                            state <= RESP;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (bus.bmem_ready) begin
                        bus.bmem_write <= 1'b0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (owner == OWN_I) begin
                        if (!squash && !bus.flush) begin
                            bus.imem_resp  <= 1'b1;
                            bus.imem_rdata <= word_select(beat, lat_addr[2]);
                            bus.imem_raddr <= lat_addr;
                        end
                    end else begin
                        bus.dmem_resp  <= 1'b1;
                        bus.dmem_rdata <= word_select(beat, lat_addr[2]);
                    end
                    last_was_data <= (owner == OWN_D);
                    squash        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a backing-memory responder with
// configurable ready/rvalid delays, a byte-level reference memory, directed
// scenarios and a randomized transaction phase.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.FAIR_ALTERNATE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests;
    int fails;

    logic [63:0] mem [logic [31:0]];

    int          rdyDelay;
    int          rvDelay;
    int          wrDelay;
    bit          injectMismatch;
    bit          chkAddr;
    logic [31:0] expBaddr;
    logic [63:0] expWbeat;
    int          writesSeen;
    logic [63:0] lastWbeat;
    int          iRespCount;
    int          dRespCount;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference memory content; untouched beats hold an address-derived pattern.
    function automatic logic [63:0] memBeat(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        if (mem.exists(b)) return mem[b];
        return {b ^ 32'hC3C3_5A5A, b + 32'h0101_0101};
    endfunction

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        logic [63:0] b;
        b = memBeat(a);
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    // Counts response pulses observed mid-cycle.
    initial begin
        iRespCount = 0;
        dRespCount = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_resp === 1'b1) iRespCount++;
            if (bus.dmem_resp === 1'b1) dRespCount++;
        end
    end

    // Backing memory: ready after rdyDelay/wrDelay cycles, beat rvDelay cycles after acceptance.
    initial begin
        bit          lastRd;
        bit          lastWr;
        logic [31:0] lastA;
        logic [63:0] lastW;
        bit          pend;
        int          pendWait;
        logic [31:0] pendA;
        int          rdyWait;
        bit          rdyArmed;
        lastRd = 0; lastWr = 0; lastA = '0; lastW = '0;
        pend = 0; pendWait = 0; pendA = '0; rdyWait = 0; rdyArmed = 0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.bmem_ready && lastRd) begin
                pend = 1; pendA = lastA; pendWait = rvDelay;
                if (chkAddr) checkOutput("rd_addr", 64'(lastA), 64'(expBaddr));
            end
            if (bus.bmem_ready && lastWr) begin
                writesSeen++;
                lastWbeat = lastW;
                if (chkAddr) begin
                    checkOutput("wr_addr", 64'(lastA), 64'(expBaddr));
                    checkOutput("wr_beat", lastW, expWbeat);
                end
            end
            bus.bmem_ready  = 1'b0;
            bus.bmem_rvalid = 1'b0;
            if (pend) begin
                if (pendWait == 0) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr  = pendA;
                    bus.bmem_rdata  = memBeat(pendA);
                    pend = 0;
                end else begin
                    if (injectMismatch) begin
                        bus.bmem_rvalid = 1'b1;
                        bus.bmem_raddr  = pendA ^ 32'h8;
                        bus.bmem_rdata  = ~memBeat(pendA);
                        injectMismatch  = 0;
                    end
                    pendWait--;
                end
            end
            lastRd = bus.bmem_read;
            lastWr = bus.bmem_write;
            lastA  = bus.bmem_addr;
            lastW  = bus.bmem_wdata;
            if (lastRd || lastWr) begin
                if (!rdyArmed) begin
                    rdyWait  = lastWr ? wrDelay : rdyDelay;
                    rdyArmed = 1;
                end
                if (rdyWait == 0) begin
                    bus.bmem_ready = 1'b1;
                    rdyArmed = 0;
                end else begin
                    rdyWait--;
                end
            end
        end
    end

    task automatic clearRequests();
        bus.input_valid = 1'b0;
        bus.dmem_rmask  = 4'b0000;
        bus.dmem_wmask  = 4'b0000;
    endtask

    task automatic waitResp(output bit gi, output bit gd, output int cyc);
        gi = 0; gd = 0; cyc = 0;
        while (!gi && !gd && cyc < 100) begin
            @(negedge clk);
            cyc++;
            gi = bus.imem_resp;
            gd = bus.dmem_resp;
        end
    endtask

    // One isolated transaction; the caller is positioned just after a falling edge.
    task automatic applyStimulus(input string tag, input bit isFetch, input logic [31:0] addr,
                                 input logic [3:0] rmask, input logic [3:0] wmask,
                                 input logic [31:0] wdata, input int r, input int d, input int w);
        logic [63:0] beat;
        logic [63:0] nbeat;
        logic [7:0]  bytes [8];
        logic [31:0] expWord;
        int          expLat;
        int          cyc;
        bit          gi;
        bit          gd;
        beat    = memBeat(addr);
        expWord = wordOf(addr);
        for (int k = 0; k < 8; k++) bytes[k] = beat[8*k +: 8];
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) bytes[(addr[2] ? 4 : 0) + i] = wdata[8*i +: 8];
        end
        for (int k = 0; k < 8; k++) nbeat[8*k +: 8] = bytes[k];
        expLat     = 4 + r + d + ((wmask != 0) ? 1 + w : 0);
        rdyDelay   = r;
        rvDelay    = d;
        wrDelay    = w;
        expBaddr   = {addr[31:3], 3'b000};
        expWbeat   = nbeat;
        writesSeen = 0;
        chkAddr    = 1;
        if (isFetch) begin
            bus.input_valid = 1'b1;
            bus.imem_addr   = addr;
        end else begin
            bus.dmem_addr  = addr;
            bus.dmem_rmask = rmask;
            bus.dmem_wmask = wmask;
            bus.dmem_wdata = wdata;
        end
        waitResp(gi, gd, cyc);
        clearRequests();
        checkOutput({tag, "_port"}, 64'({gi, gd}), isFetch ? 64'd2 : 64'd1);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
        if (isFetch) begin
            checkOutput({tag, "_irdata"}, 64'(bus.imem_rdata), 64'(expWord));
            checkOutput({tag, "_iraddr"}, 64'(bus.imem_raddr), 64'(addr));
        end else if (wmask == 0) begin
            checkOutput({tag, "_drdata"}, 64'(bus.dmem_rdata), 64'(expWord));
        end else begin
            checkOutput({tag, "_writes"}, 64'(writesSeen), 64'd1);
            mem[expBaddr] = nbeat;
        end
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 64'({bus.imem_resp, bus.dmem_resp}), 64'd0);
        chkAddr = 0;
    endtask

    // Fetch and load raised together; later a second load arrives while the fetch waits.
    task automatic testContention();
        bit          fPend;
        logic [31:0] loads [$];
        bit          refLast;
        bit          pickFetch;
        bit          gi;
        bit          gd;
        int          cyc;
        logic [31:0] fAddr;
        fAddr   = 32'h0000_0100;
        loads   = {32'h5000_0000, 32'h5000_000C};
        fPend   = 1;
        refLast = 0;
        rdyDelay = 0; rvDelay = 0; wrDelay = 0; chkAddr = 0;
        bus.input_valid = 1'b1;
        bus.imem_addr   = fAddr;
        bus.dmem_addr   = loads[0];
        bus.dmem_rmask  = 4'hF;
        bus.dmem_wmask  = 4'h0;
        for (int n = 0; n < 3; n++) begin
            pickFetch = fPend && ((loads.size() == 0) || refLast);
            waitResp(gi, gd, cyc);
            checkOutput($sformatf("contend_order%0d", n), 64'({gi, gd}), pickFetch ? 64'd2 : 64'd1);
            if (pickFetch) begin
                checkOutput($sformatf("contend_irdata%0d", n), 64'(bus.imem_rdata), 64'(wordOf(fAddr)));
                fPend = 0;
                bus.input_valid = 1'b0;
            end else begin
                checkOutput($sformatf("contend_drdata%0d", n), 64'(bus.dmem_rdata), 64'(wordOf(loads[0])));
                void'(loads.pop_front());
                if (loads.size() != 0) bus.dmem_addr = loads[0];
                else bus.dmem_rmask = 4'h0;
            end
            refLast = !pickFetch;
        end
        clearRequests();
        @(negedge clk);
    endtask

    // Fetch squashed by a flush pulse while its beat is outstanding.
    task automatic testFlush();
        int iBefore;
        rdyDelay = 0; rvDelay = 3; wrDelay = 0; chkAddr = 0;
        iBefore = iRespCount;
        bus.input_valid = 1'b1;
        bus.imem_addr   = 32'h0000_0040;
        @(negedge clk);
        checkOutput("flush_stall_busy", 64'(bus.imem_stall), 64'd1);
        @(negedge clk);
        bus.flush       = 1'b1;
        bus.input_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("flush_no_resp", 64'(iRespCount - iBefore), 64'd0);
        checkOutput("flush_read_idle", 64'(bus.bmem_read), 64'd0);
        applyStimulus("flush_next_fetch", 1, 32'h0000_0080, 4'h0, 4'h0, 32'h0, 0, 0, 0);
    endtask

    // Reset asserted while a load waits for its beat; the late beat must be ignored.
    task automatic testResetMidFlight();
        int iBefore;
        int dBefore;
        rdyDelay = 0; rvDelay = 4; wrDelay = 0; chkAddr = 0;
        bus.dmem_addr  = 32'h0000_3000;
        bus.dmem_rmask = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.dmem_rmask  = 4'h0;
        bus.input_valid = 1'b1;
        bus.imem_addr   = 32'h0000_0200;
        @(negedge clk);
        checkOutput("rst_resp", 64'({bus.imem_resp, bus.dmem_resp}), 64'd0);
        checkOutput("rst_rw", 64'({bus.bmem_read, bus.bmem_write}), 64'd0);
        checkOutput("rst_stall", 64'(bus.imem_stall), 64'd0);
        checkOutput("rst_baddr", 64'(bus.bmem_addr), 64'd0);
        checkOutput("rst_bwdata", bus.bmem_wdata, 64'd0);
        checkOutput("rst_rdata", {bus.imem_rdata, bus.dmem_rdata}, 64'd0);
        checkOutput("rst_raddr", 64'(bus.imem_raddr), 64'd0);
        bus.input_valid = 1'b0;
        rst = 1'b1;
        iBefore = iRespCount;
        dBefore = dRespCount;
        repeat (8) @(negedge clk);
        checkOutput("rst_late_beat", 64'((iRespCount - iBefore) + (dRespCount - dBefore)), 64'd0);
        checkOutput("rst_idle_read", 64'(bus.bmem_read), 64'd0);
        applyStimulus("rst_next_fetch", 1, 32'h0000_0200, 4'h0, 4'h0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        logic [3:0]  m;
        tests = 0;
        fails = 0;
        rdyDelay = 0; rvDelay = 0; wrDelay = 0;
        injectMismatch = 0; chkAddr = 0; writesSeen = 0;
        expBaddr = '0; expWbeat = '0; lastWbeat = '0;
        rst = 1'b0;
        bus.flush      = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        clearRequests();
        mem[32'h1000_0000] = 64'h1111_2222_3333_4444;
        mem[32'h2000_0000] = 64'hAAAA_AAAA_BBBB_BBBB;
        mem[32'h0000_3000] = 64'h0123_4567_89AB_CDEF;

        repeat (3) @(negedge clk);
        checkOutput("reset_resp", 64'({bus.imem_resp, bus.dmem_resp}), 64'd0);
        checkOutput("reset_rw", 64'({bus.bmem_read, bus.bmem_write}), 64'd0);
        checkOutput("reset_addr", 64'(bus.bmem_addr), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("load", 0, 32'h1000_0004, 4'hF, 4'h0, 32'h0, 0, 0, 0);
        checkOutput("load_word", 64'(bus.dmem_rdata), 64'h1111_2222);

        applyStimulus("store", 0, 32'h2000_0000, 4'h0, 4'b0011, 32'h0000_1234, 0, 0, 0);
        checkOutput("store_beat", lastWbeat, 64'hAAAA_AAAA_BBBB_1234);

        testFlush();
        testContention();

        injectMismatch = 1;
        applyStimulus("mismatch", 0, 32'h0000_3000, 4'hF, 4'h0, 32'h0, 0, 2, 0);
        checkOutput("mismatch_consumed", 64'(injectMismatch), 64'd0);

        testResetMidFlight();

        for (int n = 0; n < 30; n++) begin
            a    = 32'h4000_0000 + 32'($urandom_range(0, 3)) * 8 + 32'($urandom_range(0, 1)) * 4;
            kind = $urandom_range(0, 2);
            m    = 4'($urandom_range(1, 15));
            case (kind)
                0: applyStimulus($sformatf("rnd%0d_fetch", n), 1, a, 4'h0, 4'h0, 32'h0,
                                 $urandom_range(0, 2), $urandom_range(0, 2), 0);
                1: applyStimulus($sformatf("rnd%0d_load", n), 0, a, m, 4'h0, 32'h0,
                                 $urandom_range(0, 2), $urandom_range(0, 2), 0);
                default: applyStimulus($sformatf("rnd%0d_store", n), 0, a, 4'h0, m, $urandom,
                                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
